// File: rtl/display_scan_mux.sv
// 4-digit common-anode 7-segment scan multiplexer driven by one divider tap.
// Shadows the displayed value per frame, optional leading-zero blanking, anti-ghost gap.
module display_scan_mux #(
    parameter int unsigned TAP_SEL      = 16,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [17:0] div_i,
    input  logic        en_i,
    input  logic [15:0] value_i,
    input  logic [3:0]  dp_i,
    input  logic        lz_en_i,
    output logic [3:0]  anode_o,
    output logic [6:0]  seg_o,
    output logic        dp_o
);

    localparam int unsigned CntW   = (BLANK_CYCLES > 2) ? $clog2(BLANK_CYCLES) : 1;
    localparam int unsigned GapVal = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
    localparam logic [CntW-1:0] GapLoad = GapVal[CntW-1:0];

    typedef enum logic [0:0] {StGap, StScan} state_e;

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [CntW-1:0]   gap_cnt_q, gap_cnt_d;
    logic              s1_q, s2_q, s3_q;
    logic              tick;
    logic [15:0]       sh_val_q, sh_val_d;
    logic [3:0]        sh_dp_q, sh_dp_d;
    logic              sh_lz_q, sh_lz_d;
    logic              frame_start;
    logic [3:0]        anode_d;
    logic [6:0]        seg_d;
    logic              dp_d;
    logic [15:0]       upper;
    logic              lz_blank;

    function automatic logic [6:0] hex7(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign tick = s2_q & ~s3_q;

    // State, sync chain, shadow and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StGap;
            idx_q     <= 2'd0;
            gap_cnt_q <= '0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            sh_val_q  <= 16'h0000;
            sh_dp_q   <= 4'h0;
            sh_lz_q   <= 1'b0;
            anode_o   <= 4'b1111;
            seg_o     <= 7'h7F;
            dp_o      <= 1'b1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            gap_cnt_q <= gap_cnt_d;
            s1_q      <= div_i[TAP_SEL];
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            sh_val_q  <= sh_val_d;
            sh_dp_q   <= sh_dp_d;
            sh_lz_q   <= sh_lz_d;
            anode_o   <= anode_d;
            seg_o     <= seg_d;
            dp_o      <= dp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gap_cnt_d = gap_cnt_q;
        if (!en_i) begin
            state_d   = StGap;
            gap_cnt_d = '0;
        end else begin
            unique case (state_q)
                StScan: begin
                    if (tick) begin
                        idx_d = idx_q + 2'd1;
                        if (BLANK_CYCLES > 0) begin
                            state_d   = StGap;
                            gap_cnt_d = GapLoad;
                        end
                    end
                end
                StGap: begin
                    if (gap_cnt_q == '0) begin
                        state_d = StScan;
                    end else begin
                        gap_cnt_d = gap_cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A new frame begins whenever digit 0 becomes lit, including the 3->0 wrap with no gap
    assign frame_start = (state_d == StScan) && (idx_d == 2'd0) &&
                         !((state_q == StScan) && (idx_q == 2'd0));

    always_comb begin
        sh_val_d = sh_val_q;
        sh_dp_d  = sh_dp_q;
        sh_lz_d  = sh_lz_q;
        if (frame_start) begin
            sh_val_d = value_i;
            sh_dp_d  = dp_i;
            sh_lz_d  = lz_en_i;
        end
    end

    always_comb begin
        upper    = sh_val_d >> {idx_d, 2'b00};
        lz_blank = sh_lz_d && (idx_d != 2'd0) && (upper == 16'h0000);
        anode_d  = 4'b1111;
        seg_d    = 7'h7F;
        dp_d     = 1'b1;
        if (state_d == StScan) begin
            anode_d = ~(4'b0001 << idx_d);
            seg_d   = lz_blank ? 7'h7F : hex7(upper[3:0]);
            dp_d    = ~sh_dp_d[idx_d];
        end
    end

endmodule
